rr_switch_allocator: RTL and testbench
======================================

RR_SWITCH_ALLOCATOR -- requirements
Module: rr_switch_allocator

Interface
REQ-001 SHALL have parameter PORT_N, default 5: crossbar port count, 2..16.
REQ-002 SHALL derive localparam SEL_W = $clog2(PORT_N): selector width, matching the crossbar mux_in_sel_i/mux_out_sel_i.
REQ-003 SHALL have port clk_i  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req_i  input  PORT_N  per-input-port flit valid (input buffer non-empty).
REQ-006 SHALL have port dest_i  input  PORT_N*SEL_W  per-input destination output port, packed (port g at bits [SEL_W*(g+1)-1 : SEL_W*g]).
REQ-007 SHALL have port tail_i  input  PORT_N  per-input tail-flit marker for the flit at the head of the buffer.
REQ-008 SHALL have port out_ready_i  input  PORT_N  per-output downstream can accept a flit this cycle.
REQ-009 SHALL have port grant_o  output  PORT_N  one-hot pop strobe to the winning input buffer; flit moves on this cycle.
REQ-010 SHALL have port mux_in_sel_o  output  SEL_W  crossbar input selector, registered.
REQ-011 SHALL have port mux_out_sel_o  output  SEL_W  crossbar output selector, registered.
REQ-012 SHALL have port out_valid_o  output  PORT_N  one-hot valid qualifying crossbar data_o toward the downstream port.
REQ-013 SHALL have port busy_o  output  1  high while a connection is held (state XFER).

Function
REQ-014 SHALL implement a two-state FSM: IDLE (no connection) and XFER (connection owner -> output held).
REQ-015 Eligibility: input i SHALL be eligible when req_i[i]=1, dest_i[i] < PORT_N, and out_ready_i[dest_i[i]]=1; dest_i >= PORT_N is never eligible.
REQ-016 In IDLE, SHALL pick the first eligible input scanning i = ptr, ptr+1, ... modulo PORT_N; if any, next cycle: state XFER, mux_in_sel_o = winner, mux_out_sel_o = dest_i[winner] (latched).
REQ-017 In IDLE, grant_o and out_valid_o SHALL be all-zero (arbitration costs exactly 1 cycle per packet).
REQ-018 In XFER, grant_o[mux_in_sel_o] and out_valid_o[mux_out_sel_o] SHALL be asserted combinationally iff req_i[mux_in_sel_o] AND out_ready_i[mux_out_sel_o]; all other bits zero.
REQ-019 In XFER, dest_i of the owner SHALL be ignored after latching; the path stays fixed until tail.
REQ-020 On a granted flit with tail_i[owner]=1, SHALL return to IDLE next cycle and set ptr = (owner+1) mod PORT_N.
REQ-021 Stall (owner req low or output not ready) SHALL hold XFER, selectors and ptr unchanged, with no timeout.
REQ-022 A single-flit packet (head = tail) SHALL take 2 cycles: arbitrate, then transfer; peak throughput is 1 flit/cycle within a packet.
REQ-023 ptr SHALL change only on tail transfer; non-winning requests SHALL NOT alter it.
REQ-024 At most one grant_o bit and one out_valid_o bit SHALL be high in any cycle.

Reset
REQ-025 On rst_ni low, immediately and regardless of clock: state IDLE, ptr 0, mux_in_sel_o 0, mux_out_sel_o 0, grant_o 0, out_valid_o 0, busy_o 0.
REQ-026 Reset mid-packet SHALL abandon the connection with no further grants; after release, arbitration restarts from port 0.
REQ-027 Outputs SHALL be valid from the first rising edge after rst_ni deasserts.

Verification (PORT_N=5)
REQ-028 Single flit: req_i=00100, dest port 2 = 4, tail=1, out_ready=11111 -> cycle 1: sels 2/4 and busy=1; cycle 1: grant_o=00100, out_valid_o=10000; cycle 2: IDLE, ptr=3.
REQ-029 Round-robin: req_i=11111 held, all tail, all dest=0, ready -> grants cycle through ports 0,1,2,3,4,0, one per 2 cycles.
REQ-030 Backpressure: owner 1 -> out 3, 3-flit packet, out_ready_i[3] low for 4 cycles mid-packet -> grant_o=0 during stall, sels held, 3 grants total, tail then IDLE.
REQ-031 Ineligible skip: ptr=0, req_i=00011, dest0=2 (not ready), dest1=3 (ready) -> input 1 wins; dest_i=6 on a sole requester -> no grant, stays IDLE.
REQ-032 Reset mid-packet: assert rst_ni low during flit 2 of 4 -> all outputs 0 without clock edge; after release, req_i=10001 -> port 0 wins.
REQ-033 Assertion check throughout all scenarios: grant_o and out_valid_o each $onehot0; out_valid_o nonzero iff grant_o nonzero.

Source files
------------

// File: rtl/rr_switch_allocator.sv
// Round-robin switch allocator for a wormhole crossbar: one input-to-output
// connection at a time, held from head flit to tail flit.
module rr_switch_allocator #(
  parameter int PORT_N = 5,
  localparam int SEL_W = $clog2(PORT_N)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [PORT_N-1:0]       req_i,
  input  logic [PORT_N*SEL_W-1:0] dest_i,
  input  logic [PORT_N-1:0]       tail_i,
  input  logic [PORT_N-1:0]       out_ready_i,
  output logic [PORT_N-1:0]       grant_o,
  output logic [SEL_W-1:0]        mux_in_sel_o,
  output logic [SEL_W-1:0]        mux_out_sel_o,
  output logic [PORT_N-1:0]       out_valid_o,
  output logic                    busy_o
);

  typedef enum logic {IDLE = 1'b0, XFER = 1'b1} state_t;

  state_t           state, state_nxt;
  logic [SEL_W-1:0] ptr, ptr_nxt;
  logic [SEL_W-1:0] in_sel, in_sel_nxt;
  logic [SEL_W-1:0] out_sel, out_sel_nxt;

  logic [SEL_W-1:0]  dest_a [PORT_N];
  logic [PORT_N-1:0] eligible;
  logic              found;
  logic [SEL_W-1:0]  win, win_dest;
  logic              owner_req, owner_ready, owner_tail, go;

  // Out-of-range destinations never match any j, so they are never eligible.
  always_comb begin
    eligible = '0;
    for (int unsigned i = 0; i < PORT_N; i++) begin
      dest_a[i] = dest_i[SEL_W*i +: SEL_W];
      for (int unsigned j = 0; j < PORT_N; j++) begin
        if (req_i[i] && (dest_a[i] == SEL_W'(j)) && out_ready_i[j])
          eligible[i] = 1'b1;
      end
    end
  end

  // Rotating priority as two linear passes: ports at/after ptr, then ports below it.
  always_comb begin
    found    = 1'b0;
    win      = '0;
    win_dest = '0;
    for (int unsigned j = 0; j < PORT_N; j++) begin
      if (!found && (SEL_W'(j) >= ptr) && eligible[j]) begin
        found    = 1'b1;
        win      = SEL_W'(j);
        win_dest = dest_a[j];
      end
    end
    for (int unsigned j = 0; j < PORT_N; j++) begin
      if (!found && (SEL_W'(j) < ptr) && eligible[j]) begin
        found    = 1'b1;
        win      = SEL_W'(j);
        win_dest = dest_a[j];
      end
    end
  end

  always_comb begin
    owner_req   = 1'b0;
    owner_ready = 1'b0;
    owner_tail  = 1'b0;
    for (int unsigned j = 0; j < PORT_N; j++) begin
      if (in_sel == SEL_W'(j)) begin
        owner_req  = req_i[j];
        owner_tail = tail_i[j];
      end
      if (out_sel == SEL_W'(j))
        owner_ready = out_ready_i[j];
    end
    go = (state == XFER) && owner_req && owner_ready;
    grant_o     = '0;
    out_valid_o = '0;
    for (int unsigned j = 0; j < PORT_N; j++) begin
      grant_o[j]     = go && (in_sel == SEL_W'(j));
      out_valid_o[j] = go && (out_sel == SEL_W'(j));
    end
  end

  always_comb begin
    state_nxt   = state;
    ptr_nxt     = ptr;
    in_sel_nxt  = in_sel;
    out_sel_nxt = out_sel;
    case (state)
      IDLE: begin
        if (found) begin
          state_nxt   = XFER;
          in_sel_nxt  = win;
          out_sel_nxt = win_dest;
        end
      end
      XFER: begin
        if (go && owner_tail) begin
          state_nxt = IDLE;
          ptr_nxt   = (in_sel == SEL_W'(PORT_N - 1)) ? '0 : in_sel + SEL_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state   <= IDLE;
      ptr     <= '0;
      in_sel  <= '0;
      out_sel <= '0;
    end else begin
      state   <= state_nxt;
      ptr     <= ptr_nxt;
      in_sel  <= in_sel_nxt;
      out_sel <= out_sel_nxt;
    end
  end

  assign mux_in_sel_o  = in_sel;
  assign mux_out_sel_o = out_sel;
  assign busy_o        = (state == XFER);

endmodule

// File: tb/tb_rr_switch_allocator.sv
// Scoreboard bench for rr_switch_allocator (PORT_N=5): expected grants are
// queued with the stimulus and matched as the allocator issues them.
module tb_rr_switch_allocator;

  localparam int PORT_N = 5;
  localparam int SEL_W  = 3;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic [PORT_N-1:0]       req, tail, ready;
  logic [PORT_N*SEL_W-1:0] dest;
  logic [PORT_N-1:0]       grant, out_valid;
  logic [SEL_W-1:0]        in_sel, out_sel;
  logic                    busy;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [PORT_N-1:0] g;
    logic [PORT_N-1:0] v;
  } ev_t;
  ev_t exp_q[$];
  ev_t ev;

  rr_switch_allocator #(.PORT_N(PORT_N)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .req_i        (req),
    .dest_i       (dest),
    .tail_i       (tail),
    .out_ready_i  (ready),
    .grant_o      (grant),
    .mux_in_sel_o (in_sel),
    .mux_out_sel_o(out_sel),
    .out_valid_o  (out_valid),
    .busy_o       (busy)
  );

  always #5 clk = ~clk;

  task automatic set_dest(input int p, input int d);
    dest[p*SEL_W +: SEL_W] = SEL_W'(d);
  endtask

  task automatic push_exp(input int i, input int o);
    exp_q.push_back('{g: PORT_N'(1 << i), v: PORT_N'(1 << o)});
  endtask

  // Grant/valid exclusivity every cycle, plus in-order scoreboard matching.
  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if (!$onehot0(grant) || !$onehot0(out_valid) || ((grant != 0) != (out_valid != 0))) begin
        failures++;
        $display("FAIL onehot grant=%b out_valid=%b", grant, out_valid);
      end
      if (grant != 0) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_grant grant=%b out_valid=%b expected=none", grant, out_valid);
        end else begin
          ev = exp_q.pop_front();
          if ({grant, out_valid} !== {ev.g, ev.v}) begin
            failures++;
            $display("FAIL scoreboard grant=%b out_valid=%b expected grant=%b out_valid=%b",
                     grant, out_valid, ev.g, ev.v);
          end
        end
      end
    end
  end

  task automatic test_reset();
    #3;
    checks++;
    if ({grant, out_valid, busy, in_sel, out_sel} !== '0) begin
      failures++;
      $display("FAIL reset_state grant=%b valid=%b busy=%b sels=%0d/%0d expected all 0",
               grant, out_valid, busy, in_sel, out_sel);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_single_flit();
    req = 5'b00100; tail = '1; ready = '1; dest = '0;
    set_dest(2, 4);
    push_exp(2, 4);
    @(negedge clk);
    checks++;
    if (grant !== 5'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL single_arb grant=%b busy=%b expected 00000/0", grant, busy);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || in_sel !== 3'd2 || out_sel !== 3'd4) begin
      failures++;
      $display("FAIL single_xfer busy=%b sels=%0d/%0d expected 1 2/4", busy, in_sel, out_sel);
    end
    checks++;
    if (grant !== 5'b00100 || out_valid !== 5'b10000) begin
      failures++;
      $display("FAIL single_grant grant=%b valid=%b expected 00100/10000", grant, out_valid);
    end
    @(posedge clk); #1;
    req = '0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || grant !== 5'b0) begin
      failures++;
      $display("FAIL single_idle busy=%b grant=%b expected 0/00000", busy, grant);
    end
    // ptr should now be 3: port 3 must beat port 0.
    @(posedge clk); #1;
    req = 5'b01001; dest = '0;
    push_exp(3, 0);
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (in_sel !== 3'd3) begin
      failures++;
      $display("FAIL single_ptr_next in_sel=%0d expected 3", in_sel);
    end
    @(posedge clk); #1;
    req = '0;
  endtask

  task automatic test_round_robin();
    rst_n = 1'b0; #1; rst_n = 1'b1;
    req = '1; dest = '0; tail = '1; ready = '1;
    for (int p = 0; p < 6; p++) push_exp(p % PORT_N, 0);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      checks++;
      if ((grant != 0) !== (k % 2 == 1)) begin
        failures++;
        $display("FAIL rr_cadence cycle=%0d grant=%b expected_active=%0d", k, grant, k % 2);
      end
      if (k % 2 == 1) begin
        checks++;
        if (in_sel !== SEL_W'((k / 2) % PORT_N)) begin
          failures++;
          $display("FAIL rr_order cycle=%0d in_sel=%0d expected %0d", k, in_sel, (k / 2) % PORT_N);
        end
      end
      @(posedge clk); #1;
    end
    req = '0;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL rr_pending remaining=%0d expected 0", exp_q.size());
    end
  endtask

  task automatic test_backpressure();
    int ngrant;
    logic exp_g, exp_b;
    ngrant = 0;
    for (int p = 0; p < 3; p++) push_exp(1, 3);
    for (int k = 0; k < 9; k++) begin
      req   = (k == 8) ? 5'b00000 : 5'b00010;
      tail  = (k == 7) ? 5'b00010 : 5'b00000;
      ready = (k >= 2 && k <= 5) ? 5'b10111 : 5'b11111;
      dest  = '0;
      set_dest(1, (k >= 2) ? 0 : 3);
      exp_g = (k == 1 || k == 6 || k == 7);
      exp_b = (k >= 1 && k <= 7);
      @(negedge clk);
      if (grant != 0) ngrant++;
      checks++;
      if (grant !== (exp_g ? 5'b00010 : 5'b00000) || busy !== exp_b) begin
        failures++;
        $display("FAIL bp_cycle cycle=%0d grant=%b busy=%b expected %b/%b",
                 k, grant, busy, exp_g ? 5'b00010 : 5'b00000, exp_b);
      end
      if (exp_b) begin
        checks++;
        if (in_sel !== 3'd1 || out_sel !== 3'd3) begin
          failures++;
          $display("FAIL bp_sels cycle=%0d sels=%0d/%0d expected 1/3", k, in_sel, out_sel);
        end
      end
      @(posedge clk); #1;
    end
    checks++;
    if (ngrant != 3) begin
      failures++;
      $display("FAIL bp_grant_count count=%0d expected 3", ngrant);
    end
  endtask

  task automatic test_ineligible_skip();
    rst_n = 1'b0; #1; rst_n = 1'b1;
    req = 5'b00011; tail = '1; ready = 5'b11011; dest = '0;
    set_dest(0, 2); set_dest(1, 3);
    push_exp(1, 3);
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || in_sel !== 3'd1 || out_sel !== 3'd3) begin
      failures++;
      $display("FAIL skip_winner busy=%b sels=%0d/%0d expected 1 1/3", busy, in_sel, out_sel);
    end
    @(posedge clk); #1;
    req = '0; ready = '1;
    @(negedge clk);
    @(posedge clk); #1;
    for (int n = 0; n < 3; n++) begin
      dest = '0;
      set_dest(2, 5 + n);
      req = 5'b00100;
      for (int c = 0; c < 2; c++) begin
        @(negedge clk);
        checks++;
        if (grant !== 5'b0 || busy !== 1'b0) begin
          failures++;
          $display("FAIL bad_dest dest=%0d grant=%b busy=%b expected 00000/0", 5 + n, grant, busy);
        end
        @(posedge clk); #1;
      end
    end
    req = '0;
  endtask

  task automatic test_reset_mid_packet();
    req = 5'b01000; tail = '0; ready = '1; dest = '0;
    set_dest(3, 1);
    push_exp(3, 1); push_exp(3, 1);
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({grant, out_valid, busy, in_sel, out_sel} !== '0) begin
      failures++;
      $display("FAIL async_reset grant=%b valid=%b busy=%b sels=%0d/%0d expected all 0",
               grant, out_valid, busy, in_sel, out_sel);
    end
    @(posedge clk); #1;
    checks++;
    if (grant !== 5'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_hold grant=%b busy=%b expected 00000/0", grant, busy);
    end
    rst_n = 1'b1;
    req = 5'b10001; tail = '1; dest = '0;
    set_dest(0, 2); set_dest(4, 2);
    push_exp(0, 2);
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (in_sel !== 3'd0 || out_sel !== 3'd2 || busy !== 1'b1) begin
      failures++;
      $display("FAIL restart_port0 sels=%0d/%0d busy=%b expected 0/2 1", in_sel, out_sel, busy);
    end
    @(posedge clk); #1;
    req = '0;
  endtask

  initial begin
    #50000;
    $display("FAIL timeout simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; req = '0; tail = '0; ready = '0; dest = '0;
    test_reset();
    test_single_flit();
    test_round_robin();
    test_backpressure();
    test_ineligible_skip();
    test_reset_mid_packet();
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL final_pending remaining=%0d expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
